mod_inverse: RTL and testbench



---
 rtl/ntt_pkg.sv | 21 ++
 rtl/mod_mult.sv | 33 +++
 rtl/mod_inverse.sv | 115 +++++++++++
 tb/tb_mod_inverse.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and types for the modular inverter (NTT support logic).
package ntt_pkg;

    localparam int K    = 12;
    localparam int Q    = 3329;
    localparam int MU   = 5039;           // floor(2^(2K) / Q)
    localparam int EXP  = Q - 2;          // Fermat exponent for the inverse
    localparam int IDXW = $clog2(K);

    localparam logic [K-1:0] EXP_BITS = K'(EXP);

    typedef logic [K-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        SQUARE,
        MULT,
        DONE
    } inv_state_e;

endpackage

// File: rtl/mod_mult.sv
// Combinational modular multiply: x*y mod Q via Barrett reduction.
module mod_mult #(
    parameter int Q  = 3329,
    parameter int K  = 12,
    parameter int MU = 5039
) (
    input  logic [K-1:0] i_x,
    input  logic [K-1:0] i_y,
    output logic [K-1:0] o_z
);

    logic [2*K-1:0] w_p;
    logic [K:0]     w_q1;
    logic [2*K+1:0] w_q1mu;
    logic [K:0]     w_q2;
    logic [K+1:0]   w_r;
    logic [K+1:0]   w_r1;
    logic [K+1:0]   w_r2;

    assign w_p    = (2*K)'(i_x) * (2*K)'(i_y);
    assign w_q1   = w_p[2*K-1:K-1];
    assign w_q1mu = (2*K+2)'(w_q1) * (2*K+2)'(MU);
    assign w_q2   = (K+1)'(w_q1mu >> (K+1));

    // The true remainder is below 3Q, so K+2 bits of the difference are exact.
    assign w_r  = (K+2)'(w_p) - (K+2)'(w_q2) * (K+2)'(Q);
    assign w_r1 = (w_r  >= (K+2)'(Q)) ? w_r  - (K+2)'(Q) : w_r;
    // Barrett's estimate can undershoot by two for rare operand pairs near the
    // top of the range; a second guard keeps the output strictly below Q.
    assign w_r2 = (w_r1 >= (K+2)'(Q)) ? w_r1 - (K+2)'(Q) : w_r1;
    assign o_z  = K'(w_r2);

endmodule

// File: rtl/mod_inverse.sv
// Modular inverter: result = a^(Q-2) mod Q, fixed square-and-multiply schedule.
//
// state  | meaning
// IDLE   | waiting for start (ignored while done is still high)
// SQUARE | acc <= acc*acc mod Q
// MULT   | acc <= acc*base mod Q when exponent bit set; step bit index
// DONE   | latch acc into result; done pulses on the following cycle
module mod_inverse
    import ntt_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [K-1:0] a,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] result
);

    inv_state_e        r_state;
    inv_state_e        w_state_next;
    logic [K-1:0]      r_acc;
    logic [K-1:0]      r_base;
    logic [IDXW-1:0]   r_idx;
    logic              r_busy;
    logic              r_done;
    logic [K-1:0]      r_result;

    logic              w_accept;
    logic [K-1:0]      w_base_in;
    logic [K-1:0]      w_mm_b;
    logic [K-1:0]      w_mm;

    // Operand is below 2Q, so one conditional subtract fully reduces it.
    assign w_base_in = (a >= K'(Q)) ? a - K'(Q) : a;
    assign w_mm_b    = (r_state == MULT) ? r_base : r_acc;

    mod_mult #(
        .Q  (Q),
        .K  (K),
        .MU (MU)
    ) u_mod_mult (
        .i_x (r_acc),
        .i_y (w_mm_b),
        .o_z (w_mm)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a start is refused while the done pulse is showing.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !r_done) begin
                    w_accept     = 1'b1;
                    w_state_next = SQUARE;
                end
            end
            SQUARE:  w_state_next = MULT;
            MULT:    w_state_next = (r_idx == '0) ? DONE : SQUARE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_base   <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_busy <= (r_state == SQUARE) || (r_state == MULT);
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_base <= w_base_in;
                        r_acc  <= K'(1);
                        r_idx  <= IDXW'(K - 1);
                    end
                end
                SQUARE: r_acc <= w_mm;
                MULT: begin
                    // The cycle is spent regardless of the bit value.
                    if (EXP_BITS[r_idx]) begin
                        r_acc <= w_mm;
                    end
                    if (r_idx != '0) begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                DONE:    r_result <= r_acc;
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_mod_inverse.sv
// Self-checking bench for mod_inverse: timeline model plus directed vectors.
module tb_mod_inverse;

    localparam int QM = 3329;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] a = '0;
    logic        busy;
    logic        done;
    logic [11:0] result;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: cycles since the accepted start edge (-1 = idle).
    int          m_phase = -1;
    logic [11:0] m_op = '0;
    int          m_result = 0;

    mod_inverse dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Golden inverse by exhaustive search, independent of exponentiation.
    function automatic int model_inv(input int x);
        longint b;
        b = x % QM;
        for (int y = 1; y < QM; y++) begin
            if ((b * y) % QM == 1) return y;
        end
        return 0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: accept in idle, busy for 24 cycles, done on the 25th.
    always @(posedge clk) begin
        if (rst) begin
            m_phase  = -1;
            m_result = 0;
        end else if (m_phase < 0) begin
            if (start) begin
                m_phase = 0;
                m_op    = a;
            end
        end else begin
            m_phase++;
            if (m_phase == 25) m_result = model_inv(int'(m_op));
            if (m_phase == 26) m_phase = -1;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   32'(busy),   32'(m_phase >= 1 && m_phase <= 24));
            check("done",   32'(done),   32'(m_phase == 25));
            check("result", 32'(result), 32'(m_result));
        end
    end

    task automatic run_inv(input int op, input int exp, input bit ign, output int res);
        int n;
        int nb;
        start = 1'b1;
        a     = 12'(op);
        @(negedge clk);
        start = 1'b0;
        a     = 12'($urandom);
        n  = 0;
        nb = 0;
        while (!done && n < 40) begin
            if (ign && (n == 3 || n == 20)) begin
                start = 1'b1;
                a     = 12'd5;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
            if (busy) nb++;
        end
        check("latency", 32'(n), 32'd25);
        check("busy_cycles", 32'(nb), 32'd24);
        res = int'(result);
        if (exp >= 0) check("result_lit", 32'(res), 32'(exp));
        if (ign) begin
            start = 1'b1;
            a     = 12'd5;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int r;
        int cnt;

        // Pin the model with hand-computed inverses.
        check("model_2",    32'(model_inv(2)),    32'd1665);
        check("model_17",   32'(model_inv(17)),   32'd1175);
        check("model_3328", 32'(model_inv(3328)), 32'd3328);
        check("model_3331", 32'(model_inv(3331)), 32'd1665);
        check("model_0",    32'(model_inv(0)),    32'd0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);

        run_inv(1, 1, 1'b0, r);

        // Back-to-back known inverses.
        run_inv(2, 1665, 1'b0, r);
        check("prod_2", 32'((2 * r) % QM), 32'd1);
        run_inv(17, 1175, 1'b0, r);
        check("prod_17", 32'((17 * r) % QM), 32'd1);
        run_inv(3328, 3328, 1'b0, r);
        check("prod_3328", 32'((3328 * r) % QM), 32'd1);

        // Out-of-range operands.
        run_inv(3331, 1665, 1'b0, r);
        run_inv(0, 0, 1'b0, r);
        run_inv(3329, 0, 1'b0, r);

        // Spurious start pulses mid-run and during done are ignored.
        run_inv(3, 1110, 1'b1, r);
        run_inv(2, 1665, 1'b0, r);

        // Reset at edge 10 aborts the run.
        start = 1'b1;
        a     = 12'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_result", 32'(result), 32'd0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        run_inv(2, 1665, 1'b0, r);

        // Reset and start together: the request is dropped.
        rst   = 1'b1;
        start = 1'b1;
        a     = 12'd7;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("rst_start_drop", 32'(cnt), 32'd0);

        // Strided sweep against the golden model.
        for (int v = 1; v < QM; v += 13) begin
            run_inv(v, model_inv(v), 1'b0, r);
            check("sweep_prod", 32'((v * r) % QM), 32'd1);
        end
        run_inv(3327, model_inv(3327), 1'b0, r);
        check("sweep_prod", 32'((3327 * r) % QM), 32'd1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
